// File: rtl/button_debouncer.sv
// Push-button debouncer: input synchronizer, stability counter, registered press/release strobes.
// Optional long-press flag on `held` is built only when DEBOUNCE_LONG_PRESS_EN is defined.
module button_debouncer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 250000,
    parameter logic        INIT_LEVEL    = 1'b0,
    parameter int unsigned LONG_CYCLES   = 25000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic held
);

    localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   s;
    logic                   settle;

    always_comb begin
        s      = sync_q[SYNC_STAGES-1];
        settle = (s != out) && (cnt_q == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
            cnt_q  <= '0;
            out    <= INIT_LEVEL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
            // Any return of s to the current level restarts the window from zero.
            if (s == out || settle) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (settle) begin
                out <= s;
            end
            rise <= settle & s;
            fall <= settle & ~s;
        end
    end

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned LNG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [LNG_W-1:0] LNG_MAX = LNG_W'(LONG_CYCLES - 1);

    logic [LNG_W-1:0] lcnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lcnt_q <= '0;
            held   <= 1'b0;
        end else if (settle && !s) begin
            lcnt_q <= '0;
            held   <= 1'b0;
        end else if (out) begin
            // Counter saturates one short of LONG_CYCLES; held marks the final cycle.
            if (lcnt_q == LNG_MAX) begin
                held <= 1'b1;
            end else begin
                lcnt_q <= lcnt_q + LNG_W'(1);
            end
        end
    end
`else
    assign held = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: a per-edge reference model queues expected
// {out,rise,fall,held}, compared on the following falling edge, plus directed latency checks.
module tb_button_debouncer;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int LONG   = 10;
    localparam logic INIT = 1'b0;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic in = 1'b0;
    logic out, rise, fall, held;

    button_debouncer #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .INIT_LEVEL    (INIT),
        .LONG_CYCLES   (LONG)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .in     (in),
        .out    (out),
        .rise   (rise),
        .fall   (fall),
        .held   (held)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model of the debounce behaviour
    logic [3:0] exp_q[$];
    logic       msync[SYNC];
    logic       m_out, m_rise, m_fall, m_held, s_old, out_old;
    int         m_cnt, m_lcnt;
    int         edge_no = 0;

    always @(posedge clk) begin
        edge_no++;
        if (!resetn) begin
            for (int i = 0; i < SYNC; i++) msync[i] = INIT;
            m_out = INIT; m_cnt = 0; m_rise = 0; m_fall = 0; m_held = 0; m_lcnt = 0;
        end else begin
            s_old   = msync[SYNC-1];
            out_old = m_out;
            for (int i = SYNC - 1; i > 0; i--) msync[i] = msync[i-1];
            msync[0] = in;
            m_rise = 0;
            m_fall = 0;
            if (s_old == m_out) m_cnt = 0;
            else if (m_cnt == STABLE - 1) begin
                m_out = s_old; m_cnt = 0; m_rise = s_old; m_fall = !s_old;
            end else m_cnt++;
`ifdef DEBOUNCE_LONG_PRESS_EN
            if (m_fall) begin
                m_held = 0; m_lcnt = 0;
            end else if (out_old) begin
                if (m_lcnt >= LONG - 1) m_held = 1;
                else m_lcnt++;
            end
`endif
        end
        exp_q.push_back({m_out, m_rise, m_fall, m_held});
    end

    int   rise_cnt = 0, fall_cnt = 0, held_ones = 0;
    int   last_rise_edge = 0, last_fall_edge = 0, held_set_edge = 0, held_clr_edge = 0;
    logic held_prev = 1'b0;
    logic [3:0] e;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle", {28'd0, out, rise, fall, held}, {28'd0, e});
        end
        if (rise === 1'b1) begin rise_cnt++; last_rise_edge = edge_no; end
        if (fall === 1'b1) begin fall_cnt++; last_fall_edge = edge_no; end
        if (held === 1'b1) held_ones++;
        if (held === 1'b1 && held_prev !== 1'b1) held_set_edge = edge_no;
        if (held !== 1'b1 && held_prev === 1'b1) held_clr_edge = edge_no;
        held_prev = held;
    end

    task automatic drive(input logic v, input int n);
        in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int base, r0, f0;

    initial begin
        // Reset with the raw input high
        resetn = 1'b0;
        drive(1'b1, 3);
        check("rst_out", out, 0);
        check("rst_rise", rise, 0);
        check("rst_fall", fall, 0);
        check("rst_held", held, 0);
        resetn = 1'b1;
        drive(1'b0, 6);

        // Clean press: rise on edge SYNC+STABLE
        base = edge_no; r0 = rise_cnt; f0 = fall_cnt;
        drive(1'b1, 10);
        check("press_edge", last_rise_edge - base, SYNC + STABLE);
        check("press_rises", rise_cnt - r0, 1);
        check("press_falls", fall_cnt - f0, 0);

        // Release
        base = edge_no; r0 = rise_cnt; f0 = fall_cnt;
        drive(1'b0, 10);
        check("release_edge", last_fall_edge - base, SYNC + STABLE);
        check("release_falls", fall_cnt - f0, 1);
        check("release_rises", rise_cnt - r0, 0);

        // Glitch one cycle short of the window
        r0 = rise_cnt;
        drive(1'b1, STABLE - 1);
        drive(1'b0, 10);
        check("glitch_rises", rise_cnt - r0, 0);
        check("glitch_out", out, 0);

        // Pulse of exactly the window length
        r0 = rise_cnt; f0 = fall_cnt;
        drive(1'b1, STABLE);
        drive(1'b0, 12);
        check("pulse_rises", rise_cnt - r0, 1);
        check("pulse_falls", fall_cnt - f0, 1);

        // Bounce train then steady press
        r0 = rise_cnt;
        for (int k = 0; k < 10; k++) drive((k % 2) == 0, 2);
        base = edge_no;
        drive(1'b1, 12);
        check("bounce_edge", last_rise_edge - base, SYNC + STABLE);
        check("bounce_rises", rise_cnt - r0, 1);

        // Long press and release
        drive(1'b1, LONG + 5);
`ifdef DEBOUNCE_LONG_PRESS_EN
        check("held_delay", held_set_edge - last_rise_edge, LONG);
        check("held_level", held, 1);
`else
        check("held_off", held_ones, 0);
`endif
        base = edge_no; r0 = rise_cnt;
        drive(1'b0, 10);
        check("long_rel_edge", last_fall_edge - base, SYNC + STABLE);
        check("long_rel_rises", rise_cnt - r0, 0);
`ifdef DEBOUNCE_LONG_PRESS_EN
        check("held_clear", held_clr_edge, last_fall_edge);
`endif

        // Reset interrupting a release count in progress
        drive(1'b1, 10);
        check("pre_rst_out", out, 1);
        f0 = fall_cnt;
        drive(1'b0, 4);
        resetn = 1'b0;
        drive(1'b0, 1);
        check("midrst_out", out, 0);
        check("midrst_fall", fall_cnt - f0, 0);
        resetn = 1'b1;
        drive(1'b0, 8);
        check("midrst_nofall", fall_cnt - f0, 0);

        // Random run lengths straddling the window
        for (int k = 0; k < 80; k++) drive(1'($urandom_range(0, 1)), $urandom_range(1, 7));
        drive(1'b0, 12);

`ifndef DEBOUNCE_LONG_PRESS_EN
        check("held_never", held_ones, 0);
`endif
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
